// File: rtl/hyperbus_pkg.sv
// Shared state encoding and width helpers for the HyperBus arbiter slice.
package hyperbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DRAIN,
        ST_FAULT
    } arb_state_t;

    function automatic int unsigned port_idx_width(input int unsigned nports);
        return (nports > 1) ? 32'($clog2(nports)) : 1;
    endfunction

    function automatic int unsigned word_width(input int unsigned width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester after
// `last`, wrapping modulo NPORTS.
module rr_pick #(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned IW     = 1
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     last,
    output logic [NPORTS-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int unsigned off = 1; off <= NPORTS; off++) begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                if (!found && req[i] && (i == (32'(last) + off) % NPORTS)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Round-robin burst arbiter/sequencer in front of the HyperBus primary
// controller: grants one port, drives wrq/rrq, counts words, times out, contains faults.
module hyperbus_arbiter
    import hyperbus_pkg::*;
#(
    parameter int unsigned NPORTS    = 2,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LEN_WIDTH = 8,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NPORTS-1:0]             req,
    input  logic [NPORTS-1:0]             we,
    input  logic [NPORTS-1:0]             reg_space,
    input  logic [32*NPORTS-1:0]          adr,
    input  logic [LEN_WIDTH*NPORTS-1:0]   len,
    input  logic [2*WIDTH*NPORTS-1:0]     wdat,
    output logic [NPORTS-1:0]             gnt,
    output logic [NPORTS-1:0]             wr_ack,
    output logic [NPORTS-1:0]             rd_valid,
    output logic [2*WIDTH-1:0]            rd_dat,
    output logic [NPORTS-1:0]             done,
    output logic [NPORTS-1:0]             err,
    output logic                          fault,
    output logic [31:0]                   hb_adr,
    output logic [2*WIDTH-1:0]            hb_dat,
    output logic                          hb_reg_space,
    output logic                          hb_wrq,
    output logic                          hb_rrq,
    input  logic [2*WIDTH-1:0]            hb_dat_i,
    input  logic                          hb_ready,
    input  logic                          hb_valid,
    input  logic                          hb_busy,
    input  logic                          hb_error
);

    localparam int unsigned IW = port_idx_width(NPORTS);
    localparam int unsigned DW = word_width(WIDTH);
    localparam int unsigned CW = LEN_WIDTH + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t           state, state_d;
    logic [IW-1:0]        last, sel, pick_idx;
    logic [NPORTS-1:0]    pick;
    logic [31:0]          adr_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 we_q, reg_q, aborted;
    logic [CW-1:0]        count;
    logic [TW-1:0]        timer;

    logic xfer, wrq_raw, rrq_raw, wr_ev, rd_ev, word_ev, final_ev, timeout;
    logic grant, complete;

    rr_pick #(
        .NPORTS (NPORTS),
        .IW     (IW)
    ) u_pick (
        .req  (req),
        .last (last),
        .gnt  (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
    end

    always_comb begin
        xfer     = (state == ST_XFER);
        wrq_raw  = xfer & we_q;
        rrq_raw  = xfer & ~we_q;
        wr_ev    = wrq_raw & hb_ready;
        rd_ev    = rrq_raw & hb_valid;
        word_ev  = wr_ev | rd_ev;
        final_ev = word_ev && (count == {1'b0, len_q});
        // Abort on the edge where the idle-word timer would reach TIMEOUT.
        timeout  = xfer && !word_ev && (timer == TW'(TIMEOUT - 1));
        hb_wrq   = wrq_raw & ~final_ev;
        hb_rrq   = rrq_raw & ~final_ev;
        wr_ack   = wr_ev ? gnt : '0;
        hb_dat   = (|gnt) ? wdat[DW*sel +: DW] : '0;
    end

    assign hb_adr       = adr_q;
    assign hb_reg_space = reg_q;

    always_comb begin
        state_d  = state;
        grant    = 1'b0;
        complete = 1'b0;
        case (state)
            ST_IDLE: begin
                // A done pulse marks a cooldown cycle so a still-held req is not re-granted.
                if (hb_error) begin
                    state_d = ST_FAULT;
                end else if ((|req) && !hb_busy && !(|done)) begin
                    grant   = 1'b1;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (hb_error)                 state_d = ST_FAULT;
                else if (final_ev || timeout) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (hb_error) begin
                    state_d = ST_FAULT;
                end else if (!hb_busy) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Pointer parks on the last port so the first search starts at port 0.
            last     <= IW'(NPORTS - 1);
            sel      <= '0;
            gnt      <= '0;
            adr_q    <= '0;
            len_q    <= '0;
            we_q     <= 1'b0;
            reg_q    <= 1'b0;
            count    <= '0;
            timer    <= '0;
            aborted  <= 1'b0;
            rd_valid <= '0;
            rd_dat   <= '0;
            done     <= '0;
            err      <= '0;
            fault    <= 1'b0;
        end else begin
            rd_valid <= '0;
            done     <= '0;
            err      <= '0;
            if (grant) begin
                gnt     <= pick;
                sel     <= pick_idx;
                last    <= pick_idx;
                adr_q   <= adr[32*pick_idx +: 32];
                len_q   <= len[LEN_WIDTH*pick_idx +: LEN_WIDTH];
                we_q    <= we[pick_idx];
                reg_q   <= reg_space[pick_idx];
                count   <= '0;
                timer   <= '0;
                aborted <= 1'b0;
            end
            if (xfer && state_d != ST_FAULT) begin
                if (word_ev) begin
                    count <= count + CW'(1);
                    timer <= '0;
                end else begin
                    timer <= timer + TW'(1);
                end
                if (rd_ev) begin
                    rd_valid <= gnt;
                    rd_dat   <= hb_dat_i;
                end
                if (timeout) begin
                    err     <= gnt;
                    aborted <= 1'b1;
                end
            end
            if (complete) begin
                gnt <= '0;
                if (!aborted) done <= gnt;
            end
            if (state_d == ST_FAULT) begin
                gnt   <= '0;
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Directed bench for hyperbus_arbiter: a hand-driven controller model with
// hand-computed expectations for each scenario.
module tb_hyperbus_arbiter;

    localparam int NP = 2;
    localparam int W  = 8;
    localparam int LW = 8;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req, we, reg_space;
    logic [32*NP-1:0]  adr;
    logic [LW*NP-1:0]  len;
    logic [2*W*NP-1:0] wdat;
    logic [NP-1:0]     gnt, wr_ack, rd_valid, done, err;
    logic [2*W-1:0]    rd_dat, hb_dat, hb_dat_i;
    logic              fault, hb_reg_space, hb_wrq, hb_rrq;
    logic [31:0]       hb_adr;
    logic              hb_ready, hb_valid, hb_busy, hb_error;

    int checks   = 0;
    int failures = 0;

    bit mon_on = 1'b0;
    int p0_acks, p0_done, p1_strobes, p1_rdv, p1_done;

    always #5 clk = ~clk;

    hyperbus_arbiter #(
        .NPORTS    (NP),
        .WIDTH     (W),
        .LEN_WIDTH (LW),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .we           (we),
        .reg_space    (reg_space),
        .adr          (adr),
        .len          (len),
        .wdat         (wdat),
        .gnt          (gnt),
        .wr_ack       (wr_ack),
        .rd_valid     (rd_valid),
        .rd_dat       (rd_dat),
        .done         (done),
        .err          (err),
        .fault        (fault),
        .hb_adr       (hb_adr),
        .hb_dat       (hb_dat),
        .hb_reg_space (hb_reg_space),
        .hb_wrq       (hb_wrq),
        .hb_rrq       (hb_rrq),
        .hb_dat_i     (hb_dat_i),
        .hb_ready     (hb_ready),
        .hb_valid     (hb_valid),
        .hb_busy      (hb_busy),
        .hb_error     (hb_error)
    );

    always @(negedge clk) begin
        if (mon_on) begin
            p0_acks    += int'(wr_ack[0]);
            p0_done    += int'(done[0]);
            p1_rdv     += int'(rd_valid[1]);
            p1_done    += int'(done[1]);
            p1_strobes += int'(wr_ack[1]) + int'(rd_valid[1]) + int'(done[1]) + int'(err[1]) + int'(gnt[1]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        p0_acks = 0; p0_done = 0; p1_strobes = 0; p1_rdv = 0; p1_done = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; we = '0; reg_space = '0; adr = '0; len = '0; wdat = '0;
        hb_dat_i = '0; hb_ready = 1'b0; hb_valid = 1'b0; hb_busy = 1'b0; hb_error = 1'b0;
        repeat (2) cyc();
        checks++;
        if ({gnt, wr_ack, rd_valid, done, err, fault, hb_wrq, hb_rrq, hb_reg_space} !== '0
            || hb_adr !== 32'h0 || hb_dat !== 16'h0 || rd_dat !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b wr_ack=%b rd_valid=%b done=%b err=%b fault=%b wrq=%b rrq=%b adr=%h dat=%h rd_dat=%h, all required 0",
                     gnt, wr_ack, rd_valid, done, err, fault, hb_wrq, hb_rrq, hb_adr, hb_dat, rd_dat);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (gnt !== 2'b00 || fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: gnt=%b fault=%b, required 00/0", gnt, fault);
        end
    endtask

    task automatic test_single_write();
        clear_mon();
        mon_on = 1'b1;
        req = 2'b01; we = 2'b01; reg_space = 2'b00;
        adr[31:0] = 32'h100; len[7:0] = 8'd3; wdat[15:0] = 16'h1000;
        #1;
        checks++;
        if (gnt !== 2'b00) begin
            failures++;
            $display("FAIL wr_gnt_latency: gnt=%b before clock edge, required 00", gnt);
        end
        cyc(); hb_busy = 1'b1; #1;
        checks++;
        if ({gnt, hb_wrq, hb_rrq} !== 4'b0110 || hb_adr !== 32'h100 || hb_dat !== 16'h1000) begin
            failures++;
            $display("FAIL wr_grant: gnt=%b wrq=%b rrq=%b adr=%h dat=%h, required 01 1 0 00000100 1000",
                     gnt, hb_wrq, hb_rrq, hb_adr, hb_dat);
        end
        for (int k = 0; k < 4; k++) begin
            logic [15:0] exp_dat;
            logic        exp_wrq;
            exp_dat = 16'h1000 + 16'(k);
            exp_wrq = (k != 3);
            cyc(); hb_ready = 1'b1; wdat[15:0] = exp_dat; #1;
            checks++;
            if (wr_ack !== 2'b01 || hb_wrq !== exp_wrq || hb_dat !== exp_dat) begin
                failures++;
                $display("FAIL wr_word%0d: wr_ack=%b wrq=%b dat=%h, required 01 %b %h",
                         k, wr_ack, hb_wrq, hb_dat, exp_wrq, exp_dat);
            end
        end
        cyc(); hb_ready = 1'b0; #1;
        checks++;
        if ({gnt, hb_wrq, wr_ack, done} !== 7'b01_0_00_00) begin
            failures++;
            $display("FAIL wr_drain: gnt=%b wrq=%b wr_ack=%b done=%b, required 01 0 00 00", gnt, hb_wrq, wr_ack, done);
        end
        cyc(); hb_busy = 1'b0; #1;
        checks++;
        if (done !== 2'b00 || gnt !== 2'b01) begin
            failures++;
            $display("FAIL wr_drain_busy: done=%b gnt=%b, required 00 01", done, gnt);
        end
        cyc();
        checks++;
        if (done !== 2'b01 || gnt !== 2'b00) begin
            failures++;
            $display("FAIL wr_done: done=%b gnt=%b, required 01 00", done, gnt);
        end
        req = 2'b00;
        cyc(); cyc();
        mon_on = 1'b0;
        checks++;
        if (p0_acks !== 4 || p0_done !== 1 || p1_strobes !== 0) begin
            failures++;
            $display("FAIL wr_strobe_counts: acks=%0d done=%0d port1=%0d, required 4 1 0", p0_acks, p0_done, p1_strobes);
        end
    endtask

    task automatic test_single_read();
        clear_mon();
        mon_on = 1'b1;
        req = 2'b10; we = 2'b00; reg_space = 2'b10;
        adr[63:32] = 32'h2000; len[15:8] = 8'd1;
        cyc(); hb_busy = 1'b1; #1;
        checks++;
        if ({gnt, hb_rrq, hb_wrq, hb_reg_space} !== 5'b10_1_0_1 || hb_adr !== 32'h2000) begin
            failures++;
            $display("FAIL rd_grant: gnt=%b rrq=%b wrq=%b reg=%b adr=%h, required 10 1 0 1 00002000",
                     gnt, hb_rrq, hb_wrq, hb_reg_space, hb_adr);
        end
        cyc(); hb_valid = 1'b1; hb_dat_i = 16'hA5A5; #1;
        checks++;
        if (rd_valid !== 2'b00 || hb_rrq !== 1'b1) begin
            failures++;
            $display("FAIL rd_word0: rd_valid=%b rrq=%b, required 00 1", rd_valid, hb_rrq);
        end
        cyc(); hb_dat_i = 16'h5A5A; #1;
        checks++;
        if (rd_valid !== 2'b10 || rd_dat !== 16'hA5A5 || hb_rrq !== 1'b0) begin
            failures++;
            $display("FAIL rd_word1: rd_valid=%b rd_dat=%h rrq=%b, required 10 a5a5 0", rd_valid, rd_dat, hb_rrq);
        end
        cyc(); hb_dat_i = 16'hFFFF; #1;
        checks++;
        if (rd_valid !== 2'b10 || rd_dat !== 16'h5A5A || hb_rrq !== 1'b0) begin
            failures++;
            $display("FAIL rd_word2: rd_valid=%b rd_dat=%h rrq=%b, required 10 5a5a 0", rd_valid, rd_dat, hb_rrq);
        end
        cyc(); hb_valid = 1'b0; hb_busy = 1'b0; #1;
        checks++;
        if (rd_valid !== 2'b00 || rd_dat !== 16'h5A5A || done !== 2'b00) begin
            failures++;
            $display("FAIL rd_drain_drop: rd_valid=%b rd_dat=%h done=%b, required 00 5a5a 00", rd_valid, rd_dat, done);
        end
        cyc();
        checks++;
        if (done !== 2'b10 || gnt !== 2'b00) begin
            failures++;
            $display("FAIL rd_done: done=%b gnt=%b, required 10 00", done, gnt);
        end
        req = 2'b00; reg_space = 2'b00;
        cyc(); cyc();
        mon_on = 1'b0;
        checks++;
        if (p1_rdv !== 2 || p1_done !== 1 || p0_acks !== 0) begin
            failures++;
            $display("FAIL rd_strobe_counts: rd_valid=%0d done=%0d port0_acks=%0d, required 2 1 0", p1_rdv, p1_done, p0_acks);
        end
    endtask

    task automatic test_fairness();
        rst = 1'b1; #2; rst = 1'b0;
        req = 2'b11; we = 2'b11; len[7:0] = 8'd0; len[15:8] = 8'd0;
        for (int t = 0; t < 4; t++) begin
            logic [1:0] exp_g;
            bit got;
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                cyc();
                if (gnt !== 2'b00) got = 1'b1;
            end
            checks++;
            if (!got || gnt !== exp_g) begin
                failures++;
                $display("FAIL fair_gnt%0d: gnt=%b, required %b", t, gnt, exp_g);
            end
            hb_ready = 1'b1;
            cyc(); hb_ready = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                cyc();
                if (done !== 2'b00) got = 1'b1;
            end
            checks++;
            if (!got || done !== exp_g) begin
                failures++;
                $display("FAIL fair_done%0d: done=%b, required %b", t, done, exp_g);
            end
        end
        req = 2'b00;
        cyc(); cyc();
    endtask

    task automatic test_timeout();
        int bad;
        req = 2'b01; we = 2'b00; adr[31:0] = 32'h300; len[7:0] = 8'd2;
        cyc(); hb_busy = 1'b1; #1;
        checks++;
        if (gnt !== 2'b01 || hb_rrq !== 1'b1) begin
            failures++;
            $display("FAIL to_grant: gnt=%b rrq=%b, required 01 1", gnt, hb_rrq);
        end
        cyc(); hb_valid = 1'b1; hb_dat_i = 16'h1234;
        cyc(); hb_valid = 1'b0; #1;
        checks++;
        if (rd_valid !== 2'b01 || rd_dat !== 16'h1234 || err !== 2'b00) begin
            failures++;
            $display("FAIL to_first_word: rd_valid=%b rd_dat=%h err=%b, required 01 1234 00", rd_valid, rd_dat, err);
        end
        // Abort lands on the 15th edge after the edge that sampled the last hb_valid.
        bad = 0;
        for (int k = 2; k <= 15; k++) begin
            cyc();
            if (err !== 2'b00 || hb_rrq !== 1'b1 || gnt !== 2'b01) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL to_wait: %0d early cycles with err/rrq/gnt wrong, required 0", bad);
        end
        cyc();
        checks++;
        if (err !== 2'b01 || hb_rrq !== 1'b0 || gnt !== 2'b01) begin
            failures++;
            $display("FAIL to_err: err=%b rrq=%b gnt=%b, required 01 0 01", err, hb_rrq, gnt);
        end
        hb_busy = 1'b0; req = 2'b00;
        cyc();
        checks++;
        if (err !== 2'b00 || done !== 2'b00 || gnt !== 2'b00) begin
            failures++;
            $display("FAIL to_no_done: err=%b done=%b gnt=%b, required 00 00 00", err, done, gnt);
        end
        cyc();
        checks++;
        if (done !== 2'b00) begin
            failures++;
            $display("FAIL to_idle_done: done=%b, required 00", done);
        end
    endtask

    task automatic test_fault();
        int bad;
        req = 2'b10; we = 2'b10; adr[63:32] = 32'h400; len[15:8] = 8'd5; wdat[31:16] = 16'hBEEF;
        cyc(); hb_busy = 1'b1; #1;
        checks++;
        if (gnt !== 2'b10 || hb_wrq !== 1'b1 || hb_dat !== 16'hBEEF) begin
            failures++;
            $display("FAIL flt_grant: gnt=%b wrq=%b dat=%h, required 10 1 beef", gnt, hb_wrq, hb_dat);
        end
        cyc(); hb_ready = 1'b1; #1;
        checks++;
        if (wr_ack !== 2'b10 || fault !== 1'b0) begin
            failures++;
            $display("FAIL flt_ack: wr_ack=%b fault=%b, required 10 0", wr_ack, fault);
        end
        cyc(); hb_error = 1'b1;
        cyc(); hb_error = 1'b0; #1;
        checks++;
        if (fault !== 1'b1 || gnt !== 2'b00 || hb_wrq !== 1'b0 || hb_rrq !== 1'b0 || wr_ack !== 2'b00) begin
            failures++;
            $display("FAIL flt_enter: fault=%b gnt=%b wrq=%b rrq=%b wr_ack=%b, required 1 00 0 0 00",
                     fault, gnt, hb_wrq, hb_rrq, wr_ack);
        end
        hb_busy = 1'b0; req = 2'b11; we = 2'b01; hb_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (gnt !== 2'b00 || fault !== 1'b1 || wr_ack !== 2'b00 || rd_valid !== 2'b00 || hb_wrq !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL flt_sticky: %0d cycles granted or unfaulted in FAULT, required 0", bad);
        end
    endtask

    task automatic test_reset_midop();
        req = 2'b00; hb_ready = 1'b0; hb_valid = 1'b0; rst = 1'b1;
        cyc(); rst = 1'b0; #1;
        checks++;
        if (fault !== 1'b0 || gnt !== 2'b00) begin
            failures++;
            $display("FAIL rst_clears_fault: fault=%b gnt=%b, required 0 00", fault, gnt);
        end
        req = 2'b01; we = 2'b01; adr[31:0] = 32'h500; len[7:0] = 8'd7; wdat[15:0] = 16'h7777;
        cyc(); hb_busy = 1'b1; #1;
        checks++;
        if (gnt !== 2'b01 || hb_wrq !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_grant: gnt=%b wrq=%b, required 01 1", gnt, hb_wrq);
        end
        cyc(); hb_ready = 1'b1; #1;
        cyc(); #2; rst = 1'b1; #1;
        checks++;
        if ({gnt, wr_ack, rd_valid, done, err, fault, hb_wrq, hb_rrq, hb_reg_space} !== '0
            || hb_adr !== 32'h0 || hb_dat !== 16'h0) begin
            failures++;
            $display("FAIL rst_async: gnt=%b wr_ack=%b wrq=%b adr=%h dat=%h fault=%b, all required 0",
                     gnt, wr_ack, hb_wrq, hb_adr, hb_dat, fault);
        end
        hb_ready = 1'b0; hb_busy = 1'b0; req = 2'b11; we = 2'b11;
        cyc(); rst = 1'b0;
        cyc();
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL rst_fresh_gnt: gnt=%b, required 01", gnt);
        end
        req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_fairness();
        test_timeout();
        test_fault();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hyperbus_arbiter.md
# hyperbus_arbiter

Two-port (parameterisable) burst arbiter and sequencer sitting in front of the HyperBus primary controller. It accepts fixed-length read/write burst requests from NPORTS requesters and grants the controller round-robin. It drives the controller's hold-high `wrq`/`rrq` handshake, counts words on `ready`/`valid`, and releases the request after exactly the requested length. It also supplies per-port data strobes, completion pulses, a word-gap timeout and controller-fault containment.

## Interface
- `NPORTS`, 2: number of requesters (2..4).
- `WIDTH`, 8: HyperBus DQ width. Data words are 2*WIDTH bits.
- `LEN_WIDTH`, 8: burst length field width. Length is encoded as words-1.
- `TIMEOUT`, 1023: maximum cycles between word events before abort.
- `clk` in 1: controller clock.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NPORTS: burst request per port. Sampled only in IDLE; the requester holds it until `done` or `err`.
- `we` in NPORTS: 1 = write, 0 = read.
- `reg_space` in NPORTS: select register space.
- `adr` in 32*NPORTS: start address; port i is at [32*i+:32].
- `len` in LEN_WIDTH*NPORTS: words-1, per port.
- `wdat` in 2*WIDTH*NPORTS: write word per port. Must be stable while that port's `gnt` is high, and advances after each `wr_ack`.
- `gnt` out NPORTS: one-hot grant, held for the whole transaction.
- `wr_ack` out NPORTS: one-cycle pulse; the current `wdat` word was consumed.
- `rd_valid` out NPORTS: one-cycle pulse; `rd_dat` holds the next read word.
- `rd_dat` out 2*WIDTH: read word, shared by all ports.
- `done` out NPORTS: one-cycle pulse at transaction completion.
- `err` out NPORTS: one-cycle pulse on timeout abort.
- `fault` out 1: sticky; the controller reported an error.
- `hb_adr` out 32, `hb_dat` out 2*WIDTH, `hb_reg_space` out 1, `hb_wrq` out 1, `hb_rrq` out 1: to the controller.
- `hb_dat_i` in 2*WIDTH, `hb_ready` in 1, `hb_valid` in 1, `hb_busy` in 1, `hb_error` in 1: from the controller.

## Operation
- States: IDLE, XFER, DRAIN, FAULT.
- **Reset values:** state IDLE, pointer to port 0, all outputs 0, count 0.
- **IDLE:**
  - If `hb_error`, go to FAULT.
  - Otherwise, if any `req` and `!hb_busy`, pick the first requesting port searching from `last+1` modulo NPORTS (round-robin).
  - Latch that port's adr/len/we/reg_space, set `gnt`, clear the word count and timer, and go to XFER.
  - Update `last` to the granted port.
- **XFER, request drive:** `hb_rrq` and `hb_wrq` are combinational.
  - `hb_wrq` = XFER & we & !final.
  - `hb_rrq` = XFER & !we & !final.
  - `final` = word event in this cycle with count == latched len.
- **XFER, word events:** a write word event is `hb_ready` & `hb_wrq_raw`; a read word event is `hb_valid`.
  - Write event: pulse `wr_ack` on the granted port and increment count.
  - Read event: pulse `rd_valid`, register `hb_dat_i` into `rd_dat` in the same cycle, and increment count.
  - `hb_dat` = granted port's `wdat` (combinational mux).
  - `hb_adr` and `hb_reg_space` come from the latched values.
- **Final word:** the request drops in the same cycle as the final event, then go to DRAIN. Count width is LEN_WIDTH+1, so len = 2^LEN_WIDTH-1 does not wrap.
- **Timeout:** the timer clears on each word event and increments otherwise. At TIMEOUT, drop the request, pulse `err` on the granted port, and go to DRAIN (no `done`).
- **DRAIN:**
  - `hb_valid` and `hb_ready` are ignored; no further strobes reach any port.
  - When `hb_busy` is 0, pulse `done` (unless aborted), clear `gnt`, and go to IDLE.
- **FAULT:** entered from any state when `hb_error` = 1.
  - All gnt/wr_ack/rd_valid are 0, `hb_wrq`/`hb_rrq` are 0, and `fault` = 1.
  - Leave only by `rst`.
- Deasserting `req` during XFER has no effect. Reasserting `req` the same cycle `done` pulses is treated as a new request in the next IDLE.

## Timing
- **Grant latency:** `req` to `gnt` is 1 cycle when the controller is idle. `hb_wrq`/`hb_rrq` rise in the first XFER cycle.
- **Write:** one `wr_ack` per `hb_ready` cycle. The requester must present the next word before the next cycle (zero-wait).
- **Read:** `rd_valid` comes 1 cycle after `hb_valid`, with `rd_dat` valid in that cycle.
- **Completion:** `done` comes ≥1 cycle after the final event and the cycle after `hb_busy` falls. Minimum gap between grants is DRAIN plus 1 IDLE cycle.
- **Reset mid-transfer:** all outputs clear asynchronously and the transaction is discarded.

## Structure
- Shared package `hyperbus_pkg`: state encodings, port-index width `$clog2(NPORTS)`, and the word width expression 2*WIDTH.
- Sub-module `rr_pick`: a combinational round-robin priority picker with inputs req vector and last index, and output one-hot grant. It is reused by future multi-master blocks.
- The top level contains the FSM, counters, latches and muxes.

## Test plan
- **Single write:** port0 write, adr=0x100, len=3, with a controller model pulsing `hb_ready` 4 cycles → 4 `wr_ack` pulses on port0; `hb_wrq` low in the 4th ready cycle; one `done`; port1 sees no strobes.
- **Single read:** port1 read, len=1, `hb_valid` with data 0xA5A5 then 0x5A5A → `rd_valid` twice with `rd_dat` 0xA5A5 then 0x5A5A; an extra `hb_valid` in DRAIN is dropped; `done` after `hb_busy` falls.
- **Fairness:** both ports request continuously with len=0 → grants alternate 0,1,0,1 over 4 transactions, starting with port 0 after reset.
- **Timeout:** TIMEOUT=15, read len=2, model gives one `hb_valid` then stops → `err` on the granted port 15 cycles after the last event, `hb_rrq` dropped, no `done`, returns to IDLE.
- **Fault:** `hb_error` asserted mid-write → `fault`=1 next cycle and the request and grant drop; new requests are never granted until `rst`.
- **Reset mid-op:** `rst` during XFER of len=7 → all outputs 0 immediately; after release, a fresh request is granted to port 0.
